mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 40 ++++
 rtl/mem_stage_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - state encoding, size codes, width defaults and alignment helpers for mem_stage_ctrl
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size 2'b11 behaves as a word everywhere, hence the size[1] tests.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] r;
    case (size)
      SZ_BYTE: r = lo;
      SZ_HALF: r = {lo[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extraction/extension for loads and lane merge for sub-word stores
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [1:0]        lane_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o   = rdata_i;
    merge_o  = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{(DATA_W-8){~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o = rdata_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{(DATA_W-16){~unsigned_i & half_sel[15]}}, half_sel};
        merge_o = rdata_i;
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - load/store FSM in front of DATA_RAM with read-modify-write for sub-word stores
// MEM_MISALIGN_TRAP_EN: misaligned accesses respond with resp_err; otherwise they are aligned down and proceed.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_dataout
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] load_word, merge_word;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              err_q, err_d;
`endif

  // data_q carries store data until CAP, then the merged word or extended load result.
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .lane_i     (addr_q[1:0]),
    .rdata_i    (ram_dataout),
    .wdata_i    (data_q),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_unsigned;
          data_d = req_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
          addr_d = req_addr;
          err_d  = is_misaligned(req_size, req_addr[1:0]);
          if (err_d)                      state_d = ST_RESP;
          else if (req_we && req_size[1]) state_d = ST_WR;
          else                            state_d = ST_RD;
`else
          addr_d  = {req_addr[ADDR_W-1:2], align_lo(req_size, req_addr[1:0])};
          state_d = (req_we && req_size[1]) ? ST_WR : ST_RD;
`endif
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        data_d  = we_q ? merge_word : load_word;
        state_d = we_q ? ST_WR : ST_RESP;
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef MEM_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign ram_read   = (state_q == ST_RD);
  assign ram_write  = (state_q == ST_WR);
  assign resp_valid = (state_q == ST_RESP);
  assign ram_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_datain = ram_write ? data_q : '0;

`ifdef MEM_MISALIGN_TRAP_EN
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? data_q : '0;
`else
  assign resp_err   = 1'b0;
  assign resp_rdata = (resp_valid && !we_q) ? data_q : '0;
`endif

endmodule
